// File: rtl/ibuf_sync_filter_pkg.sv
// ---------------------------------------------------------------------------
// ibuf_sync_filter_pkg
// Shared constants for the input synchroniser / glitch filter slice.
//   CNT_W    : width of the per-lane stability counter
//   FILT_MAX : largest filter length the counter can represent
// ---------------------------------------------------------------------------
package ibuf_sync_filter_pkg;

   localparam int CNT_W    = 4;
   localparam int FILT_MAX = (1 << CNT_W) - 1;

endpackage

// File: rtl/ibuf_sync_filter_if.sv
// ---------------------------------------------------------------------------
// ibuf_sync_filter_if
// Bundles the pad-side inputs and the core-side status outputs of the
// input filter block.
//   I    : asynchronous pad levels (post-IBUF), one bit per lane
//   EN   : filter enable shared by all lanes
//   ACK  : per-lane clear of EVT/OVF
//   O    : filtered, synchronised level
//   RISE : one-cycle pulse after O goes 0->1
//   FALL : one-cycle pulse after O goes 1->0
//   EVT  : sticky "edge seen since last ACK"
//   OVF  : sticky "edge seen while EVT was already pending"
// master = core/pad side driving I/EN/ACK, slave = the filter block.
// ---------------------------------------------------------------------------
interface ibuf_sync_filter_if #(
   parameter int WIDTH = 4
);

   logic [WIDTH-1:0] I;
   logic             EN;
   logic [WIDTH-1:0] ACK;
   logic [WIDTH-1:0] O;
   logic [WIDTH-1:0] RISE;
   logic [WIDTH-1:0] FALL;
   logic [WIDTH-1:0] EVT;
   logic [WIDTH-1:0] OVF;

   modport master (
      output I, EN, ACK,
      input  O, RISE, FALL, EVT, OVF
   );

   modport slave (
      input  I, EN, ACK,
      output O, RISE, FALL, EVT, OVF
   );

endinterface

// File: rtl/ibuf_sync_filter_lane.sv
// ---------------------------------------------------------------------------
// ibuf_sync_filter_lane
// One input lane: 2-flop synchroniser, stability counter, filtered level,
// registered rise/fall pulses and sticky event/overflow flags.
// Ports:
//   clk_i, rst_ni : core clock, asynchronous active-low reset
//   pad_i         : asynchronous pad level
//   en_i          : filter enable (low freezes level_o and clears counter)
//   ack_i         : clears evt_o/ovf_o
//   level_o       : filtered level
//   rise_o/fall_o : one-cycle pulses, the cycle after level_o changes
//   evt_o/ovf_o   : sticky event and overflow flags
// ---------------------------------------------------------------------------
module ibuf_sync_filter_lane
   import ibuf_sync_filter_pkg::*;
#(
   parameter int   FILT_CNT  = 4,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pad_i,
   input  logic en_i,
   input  logic ack_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic evt_o,
   output logic ovf_o
);

   logic             s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             o_q, o_d;
   logic             oDly_q;
   logic             rise_q, fall_q;
   logic             evt_q, evt_d;
   logic             ovf_q, ovf_d;
   logic             laneEdge;

   // Filter: the synchronised level must disagree with O for FILT_CNT
   // consecutive enabled cycles before O follows. Any agreement (or EN low)
   // throws the partial count away, so a later mismatch starts from zero.
   always_comb begin
      o_d   = o_q;
      cnt_d = '0;
      if (en_i) begin
         if (FILT_CNT == 0) begin
            o_d = s2_q;
         end else if (s2_q != o_q) begin
            if (cnt_q == CNT_W'(FILT_CNT - 1)) begin
               o_d = s2_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Event flags: a new edge always (re)sets EVT so an event arriving in the
   // same cycle as ACK is never lost; ACK only clears OVF in that case.
   always_comb begin
      laneEdge = rise_q | fall_q;
      evt_d    = evt_q;
      ovf_d    = ovf_q;
      if (laneEdge) begin
         evt_d = 1'b1;
         if (ack_i) begin
            ovf_d = 1'b0;
         end else if (evt_q) begin
            ovf_d = 1'b1;
         end
      end else if (ack_i) begin
         evt_d = 1'b0;
         ovf_d = 1'b0;
      end
   end

   // State registers. Edge pulses compare O against its one-cycle-old copy,
   // so they appear the cycle after O moves and last exactly one cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q   <= RESET_VAL;
         s2_q   <= RESET_VAL;
         cnt_q  <= '0;
         o_q    <= RESET_VAL;
         oDly_q <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         evt_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         s1_q   <= pad_i;
         s2_q   <= s1_q;
         cnt_q  <= cnt_d;
         o_q    <= o_d;
         oDly_q <= o_q;
         rise_q <= o_q & ~oDly_q;
         fall_q <= ~o_q & oDly_q;
         evt_q  <= evt_d;
         ovf_q  <= ovf_d;
      end
   end

   assign level_o = o_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign evt_o   = evt_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/ibuf_sync_filter.sv
// ---------------------------------------------------------------------------
// ibuf_sync_filter
// Input-side pin conditioning: WIDTH independent lanes, each synchronised
// into CLK, glitch filtered, and reporting edges as pulses and sticky flags.
// Ports:
//   CLK   : core clock, all state rising-edge
//   RST_N : asynchronous active-low reset
//   io    : ibuf_sync_filter_if slave (I, EN, ACK in; O, RISE, FALL,
//           EVT, OVF out)
// Parameters:
//   WIDTH     : number of lanes
//   FILT_CNT  : stable cycles required before O changes (0 = bypass)
//   RESET_VAL : reset level of every lane (non-zero means 1)
// ---------------------------------------------------------------------------
module ibuf_sync_filter
   import ibuf_sync_filter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int FILT_CNT  = 4,
   parameter int RESET_VAL = 0
) (
   input logic                CLK,
   input logic                RST_N,
   ibuf_sync_filter_if.slave  io
);

   localparam logic             RST_LVL = (RESET_VAL != 0);
   localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RST_LVL}};

   // Reject parameter values the 4-bit counter cannot honour.
   if (FILT_CNT < 0 || FILT_CNT > FILT_MAX) begin : g_badFilt
      $error("ibuf_sync_filter: FILT_CNT out of range 0..15");
   end
   if (WIDTH < 1) begin : g_badWidth
      $error("ibuf_sync_filter: WIDTH must be at least 1");
   end

   logic [WIDTH-1:0] levelW, riseW, fallW, evtW, ovfW;

   // Lanes share only CLK, RST_N and EN; there is no cross-lane interaction.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      ibuf_sync_filter_lane #(
         .FILT_CNT  (FILT_CNT),
         .RESET_VAL (RST_VEC[i])
      ) u_lane (
         .clk_i   (CLK),
         .rst_ni  (RST_N),
         .pad_i   (io.I[i]),
         .en_i    (io.EN),
         .ack_i   (io.ACK[i]),
         .level_o (levelW[i]),
         .rise_o  (riseW[i]),
         .fall_o  (fallW[i]),
         .evt_o   (evtW[i]),
         .ovf_o   (ovfW[i])
      );
   end

   assign io.O    = levelW;
   assign io.RISE = riseW;
   assign io.FALL = fallW;
   assign io.EVT  = evtW;
   assign io.OVF  = ovfW;

endmodule

// File: tb/tb_ibuf_sync_filter.sv
// ---------------------------------------------------------------------------
// tb_ibuf_sync_filter
// Two instances: dutA with FILT_CNT=4 and dutB with FILT_CNT=0. Expected
// edge pulses (cycle, RISE, FALL) are queued by the stimulus; a monitor per
// DUT pops and compares whenever RISE|FALL is non-zero. Level/flag values
// are checked directly at hand-computed cycles.
// ---------------------------------------------------------------------------
module tb_ibuf_sync_filter;

   typedef struct {
      int         cyc;
      logic [3:0] rise;
      logic [3:0] fall;
   } pulse_t;

   logic clk = 1'b0;
   logic rstA_n;
   logic rstB_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   pulse_t qA[$];
   pulse_t qB[$];

   ibuf_sync_filter_if #(.WIDTH(4)) ifA ();
   ibuf_sync_filter_if #(.WIDTH(4)) ifB ();

   ibuf_sync_filter #(.WIDTH(4), .FILT_CNT(4), .RESET_VAL(0)) dutA (
      .CLK   (clk),
      .RST_N (rstA_n),
      .io    (ifA)
   );

   ibuf_sync_filter #(.WIDTH(4), .FILT_CNT(0), .RESET_VAL(0)) dutB (
      .CLK   (clk),
      .RST_N (rstB_n),
      .io    (ifB)
   );

   // Free-running clock and edge counter used to timestamp pulses.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitors: every observed RISE/FALL must match the queue head.
   always @(negedge clk) begin
      pulse_t p;
      if ((ifA.RISE | ifA.FALL) != 4'b0000) begin
         checks++;
         if (qA.size() == 0) begin
            failures++;
            $display("[TB] FAIL pulseA_unexpected: cyc=%0d rise=%b fall=%b required no pulse",
                     cyc, ifA.RISE, ifA.FALL);
         end else begin
            p = qA.pop_front();
            if (p.cyc != cyc || p.rise !== ifA.RISE || p.fall !== ifA.FALL) begin
               failures++;
               $display("[TB] FAIL pulseA: got cyc=%0d rise=%b fall=%b required cyc=%0d rise=%b fall=%b",
                        cyc, ifA.RISE, ifA.FALL, p.cyc, p.rise, p.fall);
            end
         end
      end
   end

   always @(negedge clk) begin
      pulse_t p;
      if ((ifB.RISE | ifB.FALL) != 4'b0000) begin
         checks++;
         if (qB.size() == 0) begin
            failures++;
            $display("[TB] FAIL pulseB_unexpected: cyc=%0d rise=%b fall=%b required no pulse",
                     cyc, ifB.RISE, ifB.FALL);
         end else begin
            p = qB.pop_front();
            if (p.cyc != cyc || p.rise !== ifB.RISE || p.fall !== ifB.FALL) begin
               failures++;
               $display("[TB] FAIL pulseB: got cyc=%0d rise=%b fall=%b required cyc=%0d rise=%b fall=%b",
                        cyc, ifB.RISE, ifB.FALL, p.cyc, p.rise, p.fall);
            end
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit selB, input logic [3:0] i,
                                input logic en, input logic [3:0] ack);
      if (selB) begin
         ifB.I = i; ifB.EN = en; ifB.ACK = ack;
      end else begin
         ifA.I = i; ifA.EN = en; ifA.ACK = ack;
      end
   endtask

   task automatic checkOutput(input string name, input logic [3:0] act,
                              input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %b required %b (cyc=%0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pushA(input int c, input logic [3:0] r, input logic [3:0] f);
      pulse_t p;
      p.cyc = c; p.rise = r; p.fall = f;
      qA.push_back(p);
   endtask

   task automatic pushB(input int c, input logic [3:0] r, input logic [3:0] f);
      pulse_t p;
      p.cyc = c; p.rise = r; p.fall = f;
      qB.push_back(p);
   endtask

   initial begin
      logic [3:0] iA;
      logic [3:0] iB;
      int c;
      int c2;

      // Reset both DUTs with all pads low.
      iA = 4'b0000;
      iB = 4'b0000;
      rstA_n = 1'b0;
      rstB_n = 1'b0;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      applyStimulus(1'b1, iB, 1'b1, 4'b0000);
      waitCycles(3);
      checkOutput("rstA_O", ifA.O, 4'b0000);
      checkOutput("rstA_EVT", ifA.EVT, 4'b0000);
      checkOutput("rstA_OVF", ifA.OVF, 4'b0000);
      checkOutput("rstB_O", ifB.O, 4'b0000);
      rstA_n = 1'b1;
      rstB_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         waitCycles(1);
         checkOutput("idle_O", ifA.O, 4'b0000);
         checkOutput("idle_flags", ifA.EVT | ifA.OVF, 4'b0000);
      end

      // Lane 0 rising step: O after 6 edges, RISE on the 7th, EVT on the 8th.
      c = cyc;
      iA[0] = 1'b1;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      pushA(c + 7, 4'b0001, 4'b0000);
      waitCycles(5);
      checkOutput("l0_O_before", ifA.O, 4'b0000);
      waitCycles(1);
      checkOutput("l0_O_after", ifA.O, 4'b0001);
      waitCycles(2);
      checkOutput("l0_EVT", ifA.EVT, 4'b0001);
      checkOutput("l0_OVF", ifA.OVF, 4'b0000);

      // Lane 1: 3-cycle glitch is filtered away.
      iA[1] = 1'b1;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      waitCycles(3);
      iA[1] = 1'b0;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      waitCycles(10);
      checkOutput("l1_glitch_O", ifA.O, 4'b0001);
      checkOutput("l1_glitch_EVT", ifA.EVT, 4'b0001);

      // Lane 1: 4-cycle pulse passes; two edges without ACK set OVF.
      c = cyc;
      iA[1] = 1'b1;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      pushA(c + 7, 4'b0010, 4'b0000);
      waitCycles(4);
      iA[1] = 1'b0;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      pushA(c + 11, 4'b0000, 4'b0010);
      waitCycles(9);
      checkOutput("l1_pulse_O", ifA.O, 4'b0001);
      checkOutput("l1_pulse_EVT", ifA.EVT, 4'b0011);
      checkOutput("l1_pulse_OVF", ifA.OVF, 4'b0010);
      applyStimulus(1'b0, iA, 1'b1, 4'b0011);
      waitCycles(1);
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      checkOutput("ack01_EVT", ifA.EVT, 4'b0000);
      checkOutput("ack01_OVF", ifA.OVF, 4'b0000);

      // Lane 2: two edges without ACK.
      c = cyc;
      iA[2] = 1'b1;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      pushA(c + 7, 4'b0100, 4'b0000);
      waitCycles(8);
      c2 = cyc;
      iA[2] = 1'b0;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      pushA(c2 + 7, 4'b0000, 4'b0100);
      waitCycles(9);
      checkOutput("l2_O", ifA.O, 4'b0001);
      checkOutput("l2_EVT", ifA.EVT, 4'b0100);
      checkOutput("l2_OVF", ifA.OVF, 4'b0100);

      // Lane 2: ACK alone clears both flags next cycle.
      applyStimulus(1'b0, iA, 1'b1, 4'b0100);
      waitCycles(1);
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      checkOutput("l2_ack_EVT", ifA.EVT, 4'b0000);
      checkOutput("l2_ack_OVF", ifA.OVF, 4'b0000);

      // Lane 2: ACK coincident with a new edge keeps EVT, clears OVF.
      c = cyc;
      iA[2] = 1'b1;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      pushA(c + 7, 4'b0100, 4'b0000);
      waitCycles(8);
      c2 = cyc;
      iA[2] = 1'b0;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      pushA(c2 + 7, 4'b0000, 4'b0100);
      waitCycles(7);
      applyStimulus(1'b0, iA, 1'b1, 4'b0100);
      waitCycles(1);
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      checkOutput("l2_ackEdge_EVT", ifA.EVT, 4'b0100);
      checkOutput("l2_ackEdge_OVF", ifA.OVF, 4'b0000);
      applyStimulus(1'b0, iA, 1'b1, 4'b0100);
      waitCycles(1);
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);

      // Lane 3: pad change while EN low is held off until EN rises.
      iA[3] = 1'b1;
      applyStimulus(1'b0, iA, 1'b0, 4'b0000);
      waitCycles(10);
      checkOutput("l3_enLow_O", ifA.O, 4'b0001);
      c = cyc;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      pushA(c + 5, 4'b1000, 4'b0000);
      waitCycles(3);
      checkOutput("l3_enRise_O_before", ifA.O, 4'b0001);
      waitCycles(1);
      checkOutput("l3_enRise_O_after", ifA.O, 4'b1001);
      waitCycles(3);

      // Lane 3: EN drops mid-count; the count restarts rather than resumes.
      iA[3] = 1'b0;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      waitCycles(4);
      applyStimulus(1'b0, iA, 1'b0, 4'b0000);
      waitCycles(5);
      checkOutput("l3_enDrop_O", ifA.O, 4'b1001);
      c = cyc;
      applyStimulus(1'b0, iA, 1'b1, 4'b0000);
      pushA(c + 5, 4'b0000, 4'b1000);
      waitCycles(3);
      checkOutput("l3_restart_O_before", ifA.O, 4'b1001);
      waitCycles(1);
      checkOutput("l3_restart_O_after", ifA.O, 4'b0001);
      waitCycles(4);

      // dutB (bypass): toggle lane 3 every 3 cycles.
      c = cyc;
      iB[3] = 1'b1;
      applyStimulus(1'b1, iB, 1'b1, 4'b0000);
      pushB(c + 4, 4'b1000, 4'b0000);
      waitCycles(2);
      checkOutput("b_O_lat_before", ifB.O, 4'b0000);
      waitCycles(1);
      checkOutput("b_O_lat_after", ifB.O, 4'b1000);
      iB[3] = 1'b0;
      applyStimulus(1'b1, iB, 1'b1, 4'b0000);
      pushB(c + 7, 4'b0000, 4'b1000);
      waitCycles(3);
      checkOutput("b_O_t2", ifB.O, 4'b0000);
      iB[3] = 1'b1;
      applyStimulus(1'b1, iB, 1'b1, 4'b0000);
      pushB(c + 10, 4'b1000, 4'b0000);
      waitCycles(3);
      checkOutput("b_O_t3", ifB.O, 4'b1000);
      iB[3] = 1'b0;
      applyStimulus(1'b1, iB, 1'b1, 4'b0000);
      pushB(c + 13, 4'b0000, 4'b1000);
      waitCycles(3);
      checkOutput("b_O_t4", ifB.O, 4'b0000);
      waitCycles(3);
      checkOutput("b_EVT", ifB.EVT, 4'b1000);
      checkOutput("b_OVF", ifB.OVF, 4'b1000);

      // dutB: reset asserted while a RISE pulse is showing.
      iB[3] = 1'b1;
      applyStimulus(1'b1, iB, 1'b1, 4'b0000);
      waitCycles(3);
      checkOutput("b_preRst_O", ifB.O, 4'b1000);
      waitCycles(1);
      checkOutput("b_preRst_RISE", ifB.RISE, 4'b1000);
      rstB_n = 1'b0;
      #1;
      checkOutput("b_rst_O", ifB.O, 4'b0000);
      checkOutput("b_rst_RISE", ifB.RISE, 4'b0000);
      checkOutput("b_rst_EVT", ifB.EVT, 4'b0000);
      checkOutput("b_rst_OVF", ifB.OVF, 4'b0000);
      iB[3] = 1'b0;
      applyStimulus(1'b1, iB, 1'b1, 4'b0000);
      waitCycles(3);
      rstB_n = 1'b1;
      waitCycles(6);
      checkOutput("b_postRst_O", ifB.O, 4'b0000);
      checkOutput("b_postRst_EVT", ifB.EVT, 4'b0000);

      // Every queued pulse must have been observed.
      waitCycles(5);
      checks++;
      if (qA.size() != 0) begin
         failures++;
         $display("[TB] FAIL pendingA: got %0d unseen pulses required 0", qA.size());
      end
      checks++;
      if (qB.size() != 0) begin
         failures++;
         $display("[TB] FAIL pendingB: got %0d unseen pulses required 0", qB.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
